// File: rtl/fb_pkg.sv
// Shared types and helpers for the triple-buffer frame scheduler.
package fb_pkg;

  localparam int unsigned NUM_BUF = 3;

  typedef logic [1:0] buf_idx_t;

  typedef enum logic [1:0] {
    BufFree,
    BufWriting,
    BufReady,
    BufReading
  } buf_state_e;

  typedef enum logic [2:0] {
    StIdle,
    StCommit,
    StSwapRd,
    StAllocWr,
    StIssue
  } fsm_state_e;

  // Frame size in bytes, rounded up to a 4 KiB page boundary.
  function automatic logic [31:0] frame_stride(input int unsigned h, input int unsigned v,
                                                input int unsigned bpp);
    logic [63:0] bytes;
    bytes = 64'(h) * 64'(v) * 64'(bpp);
    bytes = (bytes + 64'd4095) & ~64'd4095;
    return bytes[31:0];
  endfunction

endpackage

// File: rtl/fb_pick.sv
// Lowest-index search over the buffer states for a requested state.
module fb_pick
  import fb_pkg::*;
(
  input  buf_state_e states [NUM_BUF],
  input  buf_state_e want,
  output logic       found,
  output buf_idx_t   idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (!found && states[i] == want) begin
        found = 1'b1;
        idx   = buf_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/fb_scheduler.sv
// Triple-buffer frame scheduler: hands write/read buffer bases to the DDR delayer engines
// on every input vsync leading edge.
module fb_scheduler
  import fb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
  parameter int unsigned H_WIDTH       = 1920,
  parameter int unsigned V_HEIGHT      = 1080,
  parameter int unsigned BYTES_PER_PIX = 4,
  parameter bit          VS_POL        = 1'b1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vs_i,
  input  logic             wen_i,
  input  logic             ren_i,
  input  logic             wr_done_i,
  output logic             wr_start_o,
  output logic [31:0]      wr_base_o,
  output logic             rd_start_o,
  output logic [31:0]      rd_base_o,
  output logic             rd_valid_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic [CNT_W-1:0] repeat_cnt_o,
  output logic [CNT_W-1:0] abort_cnt_o
);

  localparam logic [31:0] FRAME_STRIDE = frame_stride(H_WIDTH, V_HEIGHT, BYTES_PER_PIX);

  function automatic logic [31:0] base_of(input buf_idx_t i);
    return BASE_ADDR + FRAME_STRIDE * 32'(i);
  endfunction

  fsm_state_e       state_q, state_d;
  buf_state_e       buf_q [NUM_BUF];
  buf_state_e       buf_d [NUM_BUF];
  buf_idx_t         wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic             vs_q, pending_q, pending_d, done_q, done_d, rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] drop_q, drop_d, repeat_q, repeat_d, abort_q, abort_d;
  logic [31:0]      wr_base_q, wr_base_d, rd_base_q, rd_base_d;
  logic             wr_start_q, wr_start_d, rd_start_q, rd_start_d;
  logic             vs_event, closed;

  logic     writing_found, ready_found, reading_found, free_found;
  buf_idx_t writing_idx, ready_idx, reading_idx, free_idx;

  fb_pick u_pick_writing (.states(buf_q), .want(BufWriting), .found(writing_found),
                          .idx(writing_idx));
  fb_pick u_pick_ready   (.states(buf_q), .want(BufReady),   .found(ready_found),
                          .idx(ready_idx));
  fb_pick u_pick_reading (.states(buf_q), .want(BufReading), .found(reading_found),
                          .idx(reading_idx));
  fb_pick u_pick_free    (.states(buf_q), .want(BufFree),    .found(free_found),
                          .idx(free_idx));

  assign vs_event = (vs_i == VS_POL) && (vs_q != VS_POL);
  assign closed   = done_q | wr_done_i;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    pending_d  = pending_q | vs_event;
    done_d     = done_q | wr_done_i;
    rd_valid_d = rd_valid_q;
    drop_d     = drop_q;
    repeat_d   = repeat_q;
    abort_d    = abort_q;
    wr_base_d  = wr_base_q;
    rd_base_d  = rd_base_q;
    wr_start_d = 1'b0;
    rd_start_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (pending_q) begin
          pending_d = vs_event;
          state_d   = StCommit;
        end
      end
      StCommit: begin
        done_d = 1'b0;
        if (writing_found) begin
          if (closed) begin
            if (ready_found) begin
              buf_d[ready_idx] = BufFree;
              if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
            end
            buf_d[writing_idx] = BufReady;
          end else begin
            buf_d[writing_idx] = BufFree;
            if (abort_q != '1) abort_d = abort_q + CNT_W'(1);
          end
        end
        state_d = StSwapRd;
      end
      StSwapRd: begin
        if (ren_i && ready_found) begin
          if (reading_found) buf_d[reading_idx] = BufFree;
          buf_d[ready_idx] = BufReading;
          rd_idx_d         = ready_idx;
          rd_valid_d       = 1'b1;
        end else if (ren_i && rd_valid_q) begin
          if (repeat_q != '1) repeat_d = repeat_q + CNT_W'(1);
        end
        state_d = StAllocWr;
      end
      StAllocWr: begin
        if (wen_i && free_found) begin
          buf_d[free_idx] = BufWriting;
          wr_idx_d        = free_idx;
        end
        // Issue registers load on entry to ISSUE so pulse and base appear together.
        wr_base_d  = base_of(wr_idx_d);
        rd_base_d  = base_of(rd_idx_q);
        wr_start_d = wen_i;
        rd_start_d = ren_i & rd_valid_q;
        state_d    = StIssue;
      end
      StIssue: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      for (int i = 0; i < NUM_BUF; i++) buf_q[i] <= BufFree;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      vs_q       <= ~VS_POL;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      drop_q     <= '0;
      repeat_q   <= '0;
      abort_q    <= '0;
      wr_base_q  <= BASE_ADDR;
      rd_base_q  <= BASE_ADDR;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      vs_q       <= vs_i;
      pending_q  <= pending_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      drop_q     <= drop_d;
      repeat_q   <= repeat_d;
      abort_q    <= abort_d;
      wr_base_q  <= wr_base_d;
      rd_base_q  <= rd_base_d;
      wr_start_q <= wr_start_d;
      rd_start_q <= rd_start_d;
    end
  end

  assign wr_start_o   = wr_start_q;
  assign wr_base_o    = wr_base_q;
  assign rd_start_o   = rd_start_q;
  assign rd_base_o    = rd_base_q;
  assign rd_valid_o   = rd_valid_q;
  assign drop_cnt_o   = drop_q;
  assign repeat_cnt_o = repeat_q;
  assign abort_cnt_o  = abort_q;

endmodule

// File: tb/tb_fb_scheduler.sv
// Directed bench for fb_scheduler with default parameters (stride 0x7E_9000).
module tb_fb_scheduler;

  localparam logic [31:0] B0 = 32'h1000_0000;
  localparam logic [31:0] B1 = 32'h107E_9000;
  localparam logic [31:0] B2 = 32'h10FD_2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b0;
  logic        wen = 1'b1;
  logic        ren = 1'b1;
  logic        wr_done = 1'b0;
  logic        wr_start, rd_start, rd_valid;
  logic [31:0] wr_base, rd_base;
  logic [15:0] drop_cnt, repeat_cnt, abort_cnt;

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int p_wr, p_rd;

  fb_scheduler dut (
    .clk_i(clk), .rst_i(rst), .vs_i(vs), .wen_i(wen), .ren_i(ren), .wr_done_i(wr_done),
    .wr_start_o(wr_start), .wr_base_o(wr_base), .rd_start_o(rd_start), .rd_base_o(rd_base),
    .rd_valid_o(rd_valid), .drop_cnt_o(drop_cnt), .repeat_cnt_o(repeat_cnt),
    .abort_cnt_o(abort_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_start) wr_pulses++;
    if (rd_start) rd_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Optional wr_done pulse, then a vsync rise; returns 5 edges later in the ISSUE cycle.
  task automatic frame(input bit with_done);
    @(negedge clk);
    vs = 1'b0;
    wr_done = with_done;
    @(negedge clk);
    wr_done = 1'b0;
    vs = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("early_wr_start", 32'(wr_start), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wr_base", wr_base, B0);
    check("rst_rd_base", rd_base, B0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    rst = 1'b0;

    // Frame 1: first write buffer, nothing to read yet.
    frame(1'b0);
    check("f1_wr_start", 32'(wr_start), 1);
    check("f1_wr_base", wr_base, B0);
    check("f1_rd_start", 32'(rd_start), 0);
    check("f1_rd_valid", 32'(rd_valid), 0);
    check("f1_cnts", {abort_cnt, drop_cnt | repeat_cnt}, 0);
    @(posedge clk);
    #1 check("f1_pulse_width", 32'(wr_start), 0);

    // Frame 2: buffer 0 completes and goes to the reader.
    frame(1'b1);
    check("f2_rd_start", 32'(rd_start), 1);
    check("f2_rd_base", rd_base, B0);
    check("f2_rd_valid", 32'(rd_valid), 1);
    check("f2_wr_start", 32'(wr_start), 1);
    check("f2_wr_base", wr_base, B1);

    // Frame 3: buffer 1 to reader, buffer 0 freed and reused.
    frame(1'b1);
    check("f3_rd_base", rd_base, B1);
    check("f3_wr_base", wr_base, B0);
    check("f3_drop", 32'(drop_cnt), 0);

    // Frame 4: no wr_done -> abort and repeat.
    frame(1'b0);
    check("f4_abort", 32'(abort_cnt), 1);
    check("f4_repeat", 32'(repeat_cnt), 1);
    check("f4_rd_start", 32'(rd_start), 1);
    check("f4_rd_base", rd_base, B1);
    check("f4_wr_base", wr_base, B0);

    // Reader disabled: second completed frame overwrites the unread one.
    ren = 1'b0;
    frame(1'b1);
    check("f5_wr_base", wr_base, B2);
    check("f5_rd_start", 32'(rd_start), 0);
    check("f5_drop", 32'(drop_cnt), 0);
    frame(1'b1);
    check("f6_drop", 32'(drop_cnt), 1);
    check("f6_rd_start", 32'(rd_start), 0);
    check("f6_rd_base", rd_base, B1);
    check("f6_wr_base", wr_base, B0);
    check("f6_rd_valid", 32'(rd_valid), 1);

    // Reset in the SWAP_RD cycle.
    ren = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
    vs = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_wr_base", wr_base, B0);
    check("mid_rst_rd_base", rd_base, B0);
    check("mid_rst_rd_valid", 32'(rd_valid), 0);
    check("mid_rst_drop", 32'(drop_cnt), 0);
    check("mid_rst_abort", 32'(abort_cnt), 0);
    check("mid_rst_repeat", 32'(repeat_cnt), 0);
    @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    p_wr = wr_pulses;
    p_rd = rd_pulses;
    repeat (10) @(negedge clk);
    check("no_pulse_after_rst", 32'(wr_pulses + rd_pulses), 32'(p_wr + p_rd));

    // Edges at cycles 1, 3, 5: the third arrives while pending is set and is dropped.
    p_wr = wr_pulses;
    p_rd = rd_pulses;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vs = 1'b1;
      @(negedge clk);
      vs = 1'b0;
    end
    repeat (20) @(negedge clk);
    check("close_edges_wr_pulses", 32'(wr_pulses - p_wr), 2);
    check("close_edges_rd_pulses", 32'(rd_pulses - p_rd), 0);
    check("close_edges_abort", 32'(abort_cnt), 1);
    check("close_edges_wr_base", wr_base, B0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
